square_motion_ctrl: RTL and testbench
=====================================

Name: square_motion_ctrl

Overview:
- Converts the four raw active-low push-buttons into the square position (x_square, y_square) consumed by vga_controller.
- Sits directly upstream of vga_controller and replaces its inline prescaler and move logic.
- Adds synchronisation, debouncing and edge clamping.
- Commits new positions only at the start of vertical sync, so the square never tears mid-frame.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
SIZE, 100, square edge length in pixels
STEP, 1, pixels moved per step tick
STEP_PERIOD, 1000000, vga_clk cycles per step tick
DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a button change
X_INIT, 100, reset x position (must be <= H_RES-SIZE)
Y_INIT, 100, reset y position (must be <= V_RES-SIZE)

Ports:
vga_clk  in  1  pixel clock; the only clock
reset  in  1  asynchronous, active-high reset
up_n  in  1  raw button, 0 = pressed, asynchronous
down_n  in  1  raw button, 0 = pressed, asynchronous
left_n  in  1  raw button, 0 = pressed, asynchronous
right_n  in  1  raw button, 0 = pressed, asynchronous
vs  in  1  active-low VS from video_sync_generator (vga_clk domain)
x_square  out  10  committed left edge of square
y_square  out  10  committed top edge of square
moving  out  1  1 while any debounced button is pressed

Behaviour:

Reset (asynchronous, takes effect immediately, including mid-hold or mid-debounce):
- Sync flops = 1; debounced state = released; debounce counters = 0; step counter = 0.
- vs_d = 1.
- x_pend = x_square = X_INIT; y_pend = y_square = Y_INIT; moving = 0.

Synchronisation:
- Each button passes through a 2-flop synchroniser (reset value 1).

Debounce, per button, independent:
- Counter clears whenever the synchronised value equals the stable value.
- Otherwise the counter increments.
- The stable value flips on the edge where the mismatch has persisted for DEBOUNCE_CYCLES consecutive edges; the counter clears at the same time.
- Press-to-stable latency = 2 + DEBOUNCE_CYCLES cycles.
- Any bounce shorter than DEBOUNCE_CYCLES is ignored.

Step tick:
- Free-running counter 0..STEP_PERIOD-1; tick = 1 for one cycle when count = STEP_PERIOD-1, then the counter wraps to 0.
- Counter width is ceil(log2(STEP_PERIOD)).

Move, evaluated only on tick cycles:
- Priority is up > down > left > right; exactly one axis changes per tick.
- No button pressed: pending values unchanged.
- Up: y_pend <= (y_pend >= STEP) ? y_pend-STEP : 0.
- Down: y_pend <= min(y_pend+STEP, V_RES-SIZE).
- Left: x_pend <= (x_pend >= STEP) ? x_pend-STEP : 0.
- Right: x_pend <= min(x_pend+STEP, H_RES-SIZE).
- Sums are computed at 11 bits, so no wrap-around is possible.

Commit:
- vs_d registers vs every cycle.
- On vs_d = 1 and vs = 0 (VS falling edge): x_square <= x_pend and y_square <= y_pend.
- Outputs are otherwise held.
- Tick and VS fall in the same cycle: commit takes the pre-tick pending value; the new value commits at the next frame.

moving:
- Registered OR of the four debounced pressed flags; one cycle after the stable change.

No handshake:
- Outputs are level signals, valid every cycle after reset.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, STEP_PERIOD=8, STEP=1, default geometry unless stated.)
1. Reset release -> x_square=100, y_square=100, moving=0; assert reset mid-hold after x_square=103 -> x_square=100 in the same cycle, no clock needed.
2. Debounce: right_n low 3 cycles then high -> moving stays 0, x_pend stays 100. right_n low held -> moving=1 exactly 2+4+1 cycles after the falling edge.
3. Commit: hold right_n through 5 ticks with vs=1 -> x_square stays 100. Pulse vs low -> x_square=105 on the cycle after the falling edge; y_square=100.
4. Clamps:
   - Y_INIT=378, hold down_n for 5 ticks then VS fall -> y_square=380 (V_RES-SIZE).
   - STEP=2, Y_INIT=1, hold up_n 1 tick then VS fall -> y_square=0.
   - Right clamp -> x_square=540.
5. Priority:
   - up_n and left_n both held for 3 ticks then VS fall -> y_square=97, x_square=100.
   - down_n and right_n held -> only y_square changes.
6. Coincidence: align a tick with the VS falling edge while right_n is held at x_pend=104 -> x_square=104 this frame and 105 at the next VS fall.

Source files
------------

// File: rtl/square_motion_ctrl.sv
// Button-driven square position controller for vga_controller: synchronises and
// debounces the four push-buttons, steps a pending position and commits it on VS fall.
module square_motion_ctrl #(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int SIZE            = 100,
    parameter int STEP            = 1,
    parameter int STEP_PERIOD     = 1000000,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int X_INIT          = 100,
    parameter int Y_INIT          = 100
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       up_n,
    input  logic       down_n,
    input  logic       left_n,
    input  logic       right_n,
    input  logic       vs,
    output logic [9:0] x_square,
    output logic [9:0] y_square,
    output logic       moving
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SPW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [10:0] X_MAX  = 11'(H_RES - SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_RES - SIZE);
    localparam logic [10:0] STEP11 = 11'(STEP);

    logic [3:0]     w_raw;
    logic [3:0]     w_pressed;
    logic [3:0]     r_sync1;
    logic [3:0]     r_sync2;
    logic [3:0]     r_stable;
    logic [DBW-1:0] r_dbCnt [4];
    logic [SPW-1:0] r_stepCnt;
    logic           w_tick;
    logic [9:0]     r_xPend;
    logic [9:0]     r_yPend;
    logic [9:0]     r_xSquare;
    logic [9:0]     r_ySquare;
    logic           r_vsD;
    logic           r_moving;
    logic [10:0]    w_xPend11;
    logic [10:0]    w_yPend11;
    logic [10:0]    w_xSum;
    logic [10:0]    w_ySum;
    logic [10:0]    w_xLeft;
    logic [10:0]    w_xRight;
    logic [10:0]    w_yUp;
    logic [10:0]    w_yDown;

    // Bit order is {right, left, down, up}; stable value 1 means released.
    assign w_raw     = {right_n, left_n, down_n, up_n};
    assign w_pressed = ~r_stable;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 4'hF;
            r_sync2  <= 4'hF;
            r_stable <= 4'hF;
            for (int i = 0; i < 4; i++) r_dbCnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable[i] <= r_sync2[i];
                    r_dbCnt[i]  <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + DBW'(1);
                end
            end
        end
    end

    assign w_tick = (r_stepCnt == SPW'(STEP_PERIOD - 1));

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) r_stepCnt <= '0;
        else if (w_tick) r_stepCnt <= '0;
        else r_stepCnt <= r_stepCnt + SPW'(1);
    end

    // 11-bit arithmetic keeps the clamps free of wrap-around.
    assign w_xPend11 = {1'b0, r_xPend};
    assign w_yPend11 = {1'b0, r_yPend};
    assign w_xSum    = w_xPend11 + STEP11;
    assign w_ySum    = w_yPend11 + STEP11;
    assign w_xLeft   = (w_xPend11 >= STEP11) ? (w_xPend11 - STEP11) : 11'd0;
    assign w_yUp     = (w_yPend11 >= STEP11) ? (w_yPend11 - STEP11) : 11'd0;
    assign w_xRight  = (w_xSum > X_MAX) ? X_MAX : w_xSum;
    assign w_yDown   = (w_ySum > Y_MAX) ? Y_MAX : w_ySum;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_xPend <= 10'(X_INIT);
            r_yPend <= 10'(Y_INIT);
        end else if (w_tick) begin
            if (w_pressed[0])      r_yPend <= w_yUp[9:0];
            else if (w_pressed[1]) r_yPend <= w_yDown[9:0];
            else if (w_pressed[2]) r_xPend <= w_xLeft[9:0];
            else if (w_pressed[3]) r_xPend <= w_xRight[9:0];
        end
    end

    // Committing on VS fall keeps the square from tearing mid-frame.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_vsD     <= 1'b1;
            r_xSquare <= 10'(X_INIT);
            r_ySquare <= 10'(Y_INIT);
            r_moving  <= 1'b0;
        end else begin
            r_vsD    <= vs;
            r_moving <= |w_pressed;
            if (r_vsD && !vs) begin
                r_xSquare <= r_xPend;
                r_ySquare <= r_yPend;
            end
        end
    end

    assign x_square = r_xSquare;
    assign y_square = r_ySquare;
    assign moving   = r_moving;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Directed self-checking bench for square_motion_ctrl using short debounce and step periods.
module tb_square_motion_ctrl;

    logic       vgaClk;
    logic       reset;
    logic       upN, downN, leftN, rightN;
    logic       up2N, right2N;
    logic       tieHigh;
    logic       vs;
    logic [9:0] xSq, ySq, xSq2, ySq2;
    logic       moving, moving2;

    int checks;
    int failures;
    int phase;
    bit tickSeen;

    typedef struct {
        logic up;
        logic down;
        logic left;
        logic right;
        int   ticks;
        int   expX;
        int   expY;
    } vec_t;

    vec_t vecs [8];

    square_motion_ctrl #(
        .STEP(1), .STEP_PERIOD(8), .DEBOUNCE_CYCLES(4), .X_INIT(100), .Y_INIT(100)
    ) dut (
        .vga_clk(vgaClk), .reset(reset),
        .up_n(upN), .down_n(downN), .left_n(leftN), .right_n(rightN),
        .vs(vs), .x_square(xSq), .y_square(ySq), .moving(moving)
    );

    // Second instance exercises the STEP=2 underflow clamp and the right-edge clamp.
    square_motion_ctrl #(
        .STEP(2), .STEP_PERIOD(8), .DEBOUNCE_CYCLES(4), .X_INIT(539), .Y_INIT(1)
    ) dut2 (
        .vga_clk(vgaClk), .reset(reset),
        .up_n(up2N), .down_n(tieHigh), .left_n(tieHigh), .right_n(right2N),
        .vs(vs), .x_square(xSq2), .y_square(ySq2), .moving(moving2)
    );

    initial begin
        vgaClk = 1'b0;
        forever #5 vgaClk = ~vgaClk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // One clock edge; phase tracks the DUT step counter so tick edges are known in advance.
    task automatic step();
        @(posedge vgaClk);
        if (phase == 7) begin
            phase    = 0;
            tickSeen = 1'b1;
        end else begin
            phase    = phase + 1;
            tickSeen = 1'b0;
        end
        #1;
    endtask

    task automatic waitTicks(input int n);
        int got;
        got = 0;
        while (got < n) begin
            step();
            if (tickSeen) got++;
        end
    endtask

    task automatic doReset();
        upN = 1'b1; downN = 1'b1; leftN = 1'b1; rightN = 1'b1;
        up2N = 1'b1; right2N = 1'b1;
        vs = 1'b1;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        phase = 0;
    endtask

    task automatic pulseVs();
        vs = 1'b0;
        step();
        vs = 1'b1;
    endtask

    // Press, wait out the debounce, hold for exactly n ticks, release right after the last one.
    task automatic applyStimulus(input logic up, input logic down, input logic left,
                                 input logic right, input int ticks);
        upN = ~up; downN = ~down; leftN = ~left; rightN = ~right;
        repeat (6) step();
        waitTicks(ticks);
        upN = 1'b1; downN = 1'b1; leftN = 1'b1; rightN = 1'b1;
        repeat (8) step();
    endtask

    initial begin
        int  edges;
        bit  bounceSeen;
        checks   = 0;
        failures = 0;
        phase    = 0;
        tieHigh  = 1'b1;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 5,   105, 100};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 3,   100, 97};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 3,   100, 103};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 4,   96,  100};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 285, 100, 380};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 445, 540, 100};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 105, 100, 0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2,   100, 100};

        // Reset values, then asynchronous reset during a hold.
        doReset();
        step();
        checkOutput("reset x", xSq, 100);
        checkOutput("reset y", ySq, 100);
        checkOutput("reset moving", moving, 0);
        checkOutput("reset x2", xSq2, 539);
        checkOutput("reset y2", ySq2, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3);
        pulseVs();
        checkOutput("pre-reset x", xSq, 103);
        step();
        rightN = 1'b0;
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset x", xSq, 100);
        checkOutput("async reset y", ySq, 100);
        checkOutput("async reset moving", moving, 0);
        doReset();

        // Short bounce is rejected; a held press shows moving 2+4+1 edges later.
        step();
        rightN = 1'b0;
        repeat (3) step();
        rightN = 1'b1;
        bounceSeen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            bounceSeen = bounceSeen | moving;
        end
        checkOutput("bounce moving", int'(bounceSeen), 0);
        pulseVs();
        checkOutput("bounce x", xSq, 100);
        step();
        rightN = 1'b0;
        edges  = 0;
        do begin
            step();
            edges++;
        end while (!moving && edges < 20);
        checkOutput("press-to-moving latency", edges, 7);
        rightN = 1'b1;
        repeat (8) step();
        checkOutput("release moving", moving, 0);

        // Table of held-button patterns from reset, committed by one VS fall.
        for (int v = 0; v < 8; v++) begin
            doReset();
            step();
            applyStimulus(vecs[v].up, vecs[v].down, vecs[v].left, vecs[v].right, vecs[v].ticks);
            checkOutput($sformatf("vec%0d moving after release", v), moving, 0);
            checkOutput($sformatf("vec%0d x held before VS", v), xSq, 100);
            pulseVs();
            checkOutput($sformatf("vec%0d x", v), xSq, vecs[v].expX);
            checkOutput($sformatf("vec%0d y", v), ySq, vecs[v].expY);
            step();
        end

        // Tick and VS fall on the same edge: the pre-tick pending value commits.
        doReset();
        step();
        rightN = 1'b0;
        repeat (6) step();
        waitTicks(4);
        repeat (7) step();
        vs = 1'b0;
        step();
        checkOutput("coincident commit x", xSq, 104);
        rightN = 1'b1;
        vs = 1'b1;
        repeat (8) step();
        pulseVs();
        checkOutput("next frame x", xSq, 105);
        step();

        // STEP=2 instance: up from 1 floors at 0, right from 539 clamps at 540.
        doReset();
        step();
        up2N = 1'b0;
        repeat (6) step();
        waitTicks(1);
        up2N = 1'b1;
        repeat (8) step();
        pulseVs();
        checkOutput("step2 up clamp y", ySq2, 0);
        checkOutput("step2 up clamp x", xSq2, 539);
        step();
        right2N = 1'b0;
        repeat (6) step();
        waitTicks(1);
        right2N = 1'b1;
        repeat (8) step();
        pulseVs();
        checkOutput("step2 right clamp x", xSq2, 540);
        checkOutput("step2 right clamp y", ySq2, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
